trace_sequencer: RTL and testbench

- Upstream stage of the cache controller.
- Holds a loaded memory-access trace. Each entry is 1 R/W bit (MSB, 1 = write) plus an N_PA_BITS physical address.
- Presents one entry at a time on `instruction`, advances on each rising edge of the controller's `fetch`, and drives the controller's `halt` while the next entry is unavailable or the trace is exhausted.
- Replaces the hard-coded `$readmemb` trace path with a loadable, restartable source.

---
 rtl/trace_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_trace_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_sequencer.sv
// rtl/trace_sequencer.sv - loadable, restartable memory-access trace source for the cache controller (optional TRACE_STATS_EN)
module trace_sequencer #(
    parameter int N_PA_BITS = 32,
    parameter int DEPTH     = 10000,
    parameter int ADDR_W    = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    input  logic [N_PA_BITS:0]   load_data,
    input  logic                 load_last,
    input  logic                 start,
    input  logic                 fetch,
    output logic [N_PA_BITS:0]   instruction,
    output logic                 halt,
    output logic [ADDR_W-1:0]    prog_count,
    output logic [ADDR_W:0]      trace_len,
    output logic                 done,
`ifdef TRACE_STATS_EN
    output logic [13:0]          rd_issued,
    output logic [13:0]          wr_issued,
`endif
    output logic                 load_ovf
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_STALL,
        S_DONE
    } state_t;

    state_t                state, state_n;
    logic [ADDR_W:0]       wr_ptr, wr_ptr_n;
    logic                  fetch_d;
    logic [N_PA_BITS:0]    instruction_n;
    logic                  halt_n;
    logic [ADDR_W-1:0]     prog_count_n;
    logic [ADDR_W:0]       trace_len_n;
    logic                  done_n;
    logic                  load_ovf_n;

    logic [N_PA_BITS:0]    mem [DEPTH];
    logic [N_PA_BITS:0]    rd_data;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic                  mem_re;
    logic [ADDR_W-1:0]     mem_raddr;

    logic                  advance;
    logic                  start_ok;
    logic [ADDR_W:0]       base;
    logic [ADDR_W:0]       count;

    // A held fetch level yields a single advance: only the rising edge counts.
    assign advance  = fetch & ~fetch_d;
    assign start_ok = start && (trace_len != '0);

    // Trace storage: synchronous write while loading, registered 1-cycle read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= load_data;
        end
        if (mem_re) begin
            rd_data <= mem[mem_raddr];
        end
    end

    // State and output registers; the trace memory itself is left untouched by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            fetch_d     <= 1'b0;
            instruction <= '0;
            halt        <= 1'b1;
            prog_count  <= '0;
            trace_len   <= '0;
            done        <= 1'b0;
            load_ovf    <= 1'b0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr_n;
            fetch_d     <= fetch;
            instruction <= instruction_n;
            halt        <= halt_n;
            prog_count  <= prog_count_n;
            trace_len   <= trace_len_n;
            done        <= done_n;
            load_ovf    <= load_ovf_n;
        end
    end

    // Next-state and next-output logic for loading, replay and fetch-driven stepping.
    always_comb begin
        state_n       = state;
        wr_ptr_n      = wr_ptr;
        instruction_n = instruction;
        halt_n        = halt;
        prog_count_n  = prog_count;
        trace_len_n   = trace_len;
        done_n        = done;
        load_ovf_n    = load_ovf;
        mem_we        = 1'b0;
        mem_waddr     = '0;
        mem_re        = 1'b0;
        mem_raddr     = '0;
        base          = '0;
        count         = '0;

        case (state)
            S_IDLE, S_LOAD, S_READY: begin
                if (load_valid) begin
                    // A load arriving in READY begins a fresh trace at entry 0;
                    // trace_len keeps the old value until the new load_last.
                    base = (state == S_READY) ? '0 : wr_ptr;
                    if (base < DEPTH_C) begin
                        mem_we    = 1'b1;
                        mem_waddr = base[ADDR_W-1:0];
                        count     = base + ONE_W;
                    end else begin
                        load_ovf_n = 1'b1;
                        count      = base;
                    end
                    wr_ptr_n = count;
                    if (load_last) begin
                        trace_len_n = count;
                        state_n     = (count == '0) ? S_IDLE : S_READY;
                    end else begin
                        state_n = S_LOAD;
                    end
                end else if (state == S_READY && start_ok) begin
                    prog_count_n = '0;
                    mem_re       = 1'b1;
                    mem_raddr    = '0;
                    done_n       = 1'b0;
                    halt_n       = 1'b1;
                    state_n      = S_STALL;
                end
            end

            S_STALL: begin
                instruction_n = rd_data;
                halt_n        = 1'b0;
                state_n       = S_RUN;
            end

            S_RUN: begin
                if (advance) begin
                    if (({1'b0, prog_count} + ONE_W) == trace_len) begin
                        done_n  = 1'b1;
                        halt_n  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        prog_count_n = prog_count + ONE_A;
                        mem_re       = 1'b1;
                        mem_raddr    = prog_count + ONE_A;
                        halt_n       = 1'b1;
                        state_n      = S_STALL;
                    end
                end
            end

            S_DONE: begin
                if (start_ok) begin
                    prog_count_n = '0;
                    mem_re       = 1'b1;
                    mem_raddr    = '0;
                    done_n       = 1'b0;
                    halt_n       = 1'b1;
                    state_n      = S_STALL;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

`ifdef TRACE_STATS_EN
    logic stats_clear;
    logic stats_present;

    assign stats_clear   = start_ok && ((state == S_READY && !load_valid) || state == S_DONE);
    assign stats_present = (state == S_STALL);

    // Per-run read/write counts of presented entries, saturating at the 14-bit ceiling.
    always_ff @(posedge clk) begin
        if (reset || stats_clear) begin
            rd_issued <= '0;
            wr_issued <= '0;
        end else if (stats_present) begin
            if (rd_data[N_PA_BITS]) begin
                if (wr_issued != 14'h3FFF) begin
                    wr_issued <= wr_issued + 14'd1;
                end
            end else begin
                if (rd_issued != 14'h3FFF) begin
                    rd_issued <= rd_issued + 14'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_trace_sequencer.sv
// tb/tb_trace_sequencer.sv - directed, table-driven self-checking bench for trace_sequencer
module tb_trace_sequencer;

    localparam int N_PA_BITS = 32;
    localparam int DEPTH     = 10000;
    localparam int ADDR_W    = 14;

    localparam logic [32:0] E0 = 33'h0_0000_1000;
    localparam logic [32:0] E1 = 33'h1_0000_1004;
    localparam logic [32:0] E2 = 33'h0_0001_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [32:0]       load_data;
    logic              load_last;
    logic              start;
    logic              fetch;
    logic [32:0]       instruction;
    logic              halt;
    logic [13:0]       prog_count;
    logic [14:0]       trace_len;
    logic              done;
    logic              load_ovf;
`ifdef TRACE_STATS_EN
    logic [13:0]       rd_issued;
    logic [13:0]       wr_issued;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    trace_sequencer #(
        .N_PA_BITS (N_PA_BITS),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .start       (start),
        .fetch       (fetch),
        .instruction (instruction),
        .halt        (halt),
        .prog_count  (prog_count),
        .trace_len   (trace_len),
        .done        (done),
`ifdef TRACE_STATS_EN
        .rd_issued   (rd_issued),
        .wr_issued   (wr_issued),
`endif
        .load_ovf    (load_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        lv;
        logic [32:0] ld;
        logic        ll;
        logic        st;
        logic        fe;
        logic [32:0] e_instr;
        logic        e_halt;
        logic [13:0] e_pc;
        logic [14:0] e_len;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic lv, input logic [32:0] ld, input logic ll,
                       input logic st, input logic fe, input logic [32:0] e_instr,
                       input logic e_halt, input logic [13:0] e_pc, input logic [14:0] e_len,
                       input logic e_done);
        vec_t v;
        v.rst = rst; v.lv = lv; v.ld = ld; v.ll = ll; v.st = st; v.fe = fe;
        v.e_instr = e_instr; v.e_halt = e_halt; v.e_pc = e_pc; v.e_len = e_len; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, let the rising edge take them, sample after it.
    task automatic step(input logic rst, input logic lv, input logic [32:0] ld, input logic ll,
                        input logic st, input logic fe);
        @(negedge clk);
        reset = rst; load_valid = lv; load_data = ld; load_last = ll; start = st; fetch = fe;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 33'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Start a replay and pulse fetch until done rises, bounded by a pulse budget.
    task automatic run_trace(input string name);
        step(1'b0, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0);
        idle();
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 33'h0, 1'b0, 1'b0, 1'b1);
            idle();
            if (done) break;
        end
        chk({name, ".done_reached"}, 64'(done), 64'd1);
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0; start = 1'b0; fetch = 1'b0;

        //     rst lv  ld  ll  st  fe | instr halt pc len done
        add(0, 1, E0, 0, 0, 0,  33'h0, 1, 0, 0, 0);
        add(0, 1, E1, 0, 0, 0,  33'h0, 1, 0, 0, 0);
        add(0, 1, E2, 1, 0, 0,  33'h0, 1, 0, 3, 0);
        add(0, 0, 0,  0, 0, 0,  33'h0, 1, 0, 3, 0);
        add(0, 0, 0,  0, 1, 0,  33'h0, 1, 0, 3, 0);
        add(0, 0, 0,  0, 0, 0,  E0,    0, 0, 3, 0);
        add(0, 0, 0,  0, 0, 1,  E0,    1, 1, 3, 0);
        add(0, 0, 0,  0, 0, 1,  E1,    0, 1, 3, 0);
        add(0, 0, 0,  0, 0, 0,  E1,    0, 1, 3, 0);
        add(0, 0, 0,  0, 0, 0,  E1,    0, 1, 3, 0);
        add(0, 0, 0,  0, 0, 1,  E1,    1, 2, 3, 0);
        add(0, 0, 0,  0, 0, 0,  E2,    0, 2, 3, 0);
        add(0, 0, 0,  0, 0, 0,  E2,    0, 2, 3, 0);
        add(0, 0, 0,  0, 0, 0,  E2,    0, 2, 3, 0);
        add(0, 0, 0,  0, 0, 1,  E2,    1, 2, 3, 1);
        add(0, 0, 0,  0, 0, 0,  E2,    1, 2, 3, 1);
        add(0, 1, E0, 1, 0, 0,  E2,    1, 2, 3, 1);
        add(0, 0, 0,  0, 1, 0,  E2,    1, 0, 3, 0);
        add(0, 0, 0,  0, 0, 0,  E0,    0, 0, 3, 0);
        add(0, 0, 0,  0, 0, 1,  E0,    1, 1, 3, 0);
        add(0, 0, 0,  0, 0, 1,  E1,    0, 1, 3, 0);
        add(0, 0, 0,  0, 0, 1,  E1,    0, 1, 3, 0);
        add(0, 0, 0,  0, 0, 1,  E1,    0, 1, 3, 0);
        add(0, 0, 0,  0, 0, 1,  E1,    0, 1, 3, 0);
        add(0, 0, 0,  0, 0, 1,  E1,    0, 1, 3, 0);
        add(0, 1, E0, 1, 0, 0,  E1,    0, 1, 3, 0);
        add(1, 0, 0,  0, 0, 0,  33'h0, 1, 0, 0, 0);
        add(0, 0, 0,  0, 1, 0,  33'h0, 1, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,  33'h0, 1, 0, 0, 0);

        // Reset values
        step(1'b1, 1'b0, 33'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 33'h0, 1'b0, 1'b0, 1'b0);
        chk("rst.instr", 64'(instruction), 64'h0);
        chk("rst.halt",  64'(halt),        64'd1);
        chk("rst.pc",    64'(prog_count),  64'd0);
        chk("rst.len",   64'(trace_len),   64'd0);
        chk("rst.done",  64'(done),        64'd0);
        chk("rst.ovf",   64'(load_ovf),    64'd0);

        // Table: load, run with spaced fetch edges, replay, held fetch, reset mid-RUN
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].lv, vecs[i].ld, vecs[i].ll, vecs[i].st, vecs[i].fe);
            chk($sformatf("v%0d.instr", i), 64'(instruction), 64'(vecs[i].e_instr));
            chk($sformatf("v%0d.halt",  i), 64'(halt),        64'(vecs[i].e_halt));
            chk($sformatf("v%0d.pc",    i), 64'(prog_count),  64'(vecs[i].e_pc));
            chk($sformatf("v%0d.len",   i), 64'(trace_len),   64'(vecs[i].e_len));
            chk($sformatf("v%0d.done",  i), 64'(done),        64'(vecs[i].e_done));
        end

        // Overflow: DEPTH+2 words, last two dropped, memory must not wrap
        step(1'b1, 1'b0, 33'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            logic [32:0] w;
            w = {i[0], 32'hA000_0000 + 32'(i)};
            step(1'b0, 1'b1, w, (i == DEPTH + 1), 1'b0, 1'b0);
            if (i == DEPTH - 1) chk("ovf.before", 64'(load_ovf), 64'd0);
            if (i == DEPTH)     chk("ovf.at",     64'(load_ovf), 64'd1);
        end
        chk("ovf.len",    64'(trace_len), 64'(DEPTH));
        chk("ovf.sticky", 64'(load_ovf),  64'd1);
        chk("ovf.halt",   64'(halt),      64'd1);
        step(1'b0, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("ovf.entry0", 64'(instruction), 64'h0_A000_0000);
        chk("ovf.halt0",  64'(halt),        64'd0);
        step(1'b0, 1'b0, 33'h0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("ovf.entry1", 64'(instruction), 64'h1_A000_0001);
        chk("ovf.pc1",    64'(prog_count),  64'd1);

        // Start coincident with load in READY: load wins, trace restarts at entry 0
        step(1'b1, 1'b0, 33'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, E0, 1'b1, 1'b0, 1'b0);
        chk("sim.len1", 64'(trace_len), 64'd1);
        step(1'b0, 1'b1, E1, 1'b0, 1'b1, 1'b0);
        chk("sim.len_held", 64'(trace_len), 64'd1);
        idle();
        idle();
        chk("sim.halt", 64'(halt),        64'd1);
        chk("sim.instr", 64'(instruction), 64'h0);
        step(1'b0, 1'b1, E2, 1'b1, 1'b0, 1'b0);
        chk("sim.len2", 64'(trace_len), 64'd2);
        chk("sim.ovf_clr", 64'(load_ovf), 64'd0);
        step(1'b0, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("sim.entry0", 64'(instruction), 64'(E1));
        chk("sim.pc0",    64'(prog_count),  64'd0);
        step(1'b0, 1'b0, 33'h0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("sim.entry1", 64'(instruction), 64'(E2));
        step(1'b0, 1'b0, 33'h0, 1'b0, 1'b0, 1'b1);
        chk("sim.done", 64'(done),       64'd1);
        chk("sim.pc",   64'(prog_count), 64'd1);

`ifdef TRACE_STATS_EN
        // Stats: two replays of the 3-entry trace, counters cleared by each start
        step(1'b1, 1'b0, 33'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, E0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, E1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, E2, 1'b1, 1'b0, 1'b0);
        run_trace("st1");
        chk("st1.rd", 64'(rd_issued), 64'd2);
        chk("st1.wr", 64'(wr_issued), 64'd1);
        step(1'b0, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0);
        chk("st.clr_rd", 64'(rd_issued), 64'd0);
        chk("st.clr_wr", 64'(wr_issued), 64'd0);
        idle();
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 33'h0, 1'b0, 1'b0, 1'b1);
            idle();
            if (done) break;
        end
        chk("st2.done", 64'(done), 64'd1);
        chk("st2.rd", 64'(rd_issued), 64'd2);
        chk("st2.wr", 64'(wr_issued), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
